// File: rtl/queen_checker_pkg.sv
// Shared types and helpers for the N-queen placement checker.
// Holds the FSM state encoding and the one-hot row-word decoder.
package queen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int N_DEFAULT = 8;

  // Decoder is sized for the largest supported board; callers zero-extend.
  localparam int OH_MAX   = 64;
  localparam int OH_IDX_W = 6;

  typedef struct packed {
    logic                valid;
    logic [OH_IDX_W-1:0] idx;
  } onehot_idx_t;

  function automatic onehot_idx_t onehot_to_idx(input logic [OH_MAX-1:0] word);
    onehot_idx_t res;
    logic [6:0]  cnt;
    res.idx = {OH_IDX_W{1'b0}};
    cnt     = 7'd0;
    for (int k = 0; k < OH_MAX; k++) begin
      if (word[k]) begin
        cnt     = cnt + 7'd1;
        res.idx = OH_IDX_W'(k);
      end else begin
        cnt     = cnt;
      end
    end
    res.valid = (cnt == 7'd1);
    return res;
  endfunction

endpackage

// File: rtl/queen_checker_if.sv
// Stream and status bundle between a placement source and the queen checker.
interface queen_checker_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         start;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic         pass;
  logic         onehot_err;
  logic [W-1:0] bad_i;
  logic [W-1:0] bad_j;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, done, pass, onehot_err, bad_i, bad_j
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, done, pass, onehot_err, bad_i, bad_j
  );
endinterface

// File: rtl/queen_checker_pair_scanner.sv
// Walks column pairs (i,j) in scan order, one per cycle, and flags whether
// the two queens share a row or a diagonal.
module pair_scanner #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_adv,
  input  logic [W-1:0] i_row_a,
  input  logic [W-1:0] i_row_b,
  output logic [W-1:0] o_i,
  output logic [W-1:0] o_j,
  output logic         o_last,
  output logic         o_threat
);

  logic [W-1:0] r_i;
  logic [W-1:0] r_j;
  logic [W:0]   w_a;
  logic [W:0]   w_b;
  logic [W:0]   w_row_diff;
  logic [W:0]   w_col_dist;

  // Pair counters: j runs i+1..N-1, then i steps and j restarts at i+1.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_i <= {W{1'b0}};
      r_j <= W'(1);
    end else if (i_adv && !o_last) begin
      if (r_j == W'(N - 1)) begin
        r_i <= r_i + W'(1);
        r_j <= r_i + W'(2);
      end else begin
        r_j <= r_j + W'(1);
      end
    end else begin
      r_i <= r_i;
      r_j <= r_j;
    end
  end

  // One extra bit keeps the unsigned magnitude exact for any row pair.
  assign w_a        = {1'b0, i_row_a};
  assign w_b        = {1'b0, i_row_b};
  assign w_row_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  assign w_col_dist = {1'b0, r_j} - {1'b0, r_i};

  assign o_i      = r_i;
  assign o_j      = r_j;
  assign o_last   = (r_i == W'(N - 2)) && (r_j == W'(N - 1));
  assign o_threat = (i_row_a == i_row_b) || (w_row_diff == w_col_dist);

endmodule

// File: rtl/queen_checker.sv
// Captures one one-hot row word per column, then scans every column pair for
// row/diagonal conflicts and reports pass/fail with the first offending pair.
module queen_checker
  import queen_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  queen_checker_if.slave  bus
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_row [N];
  logic [W-1:0] r_col;
  logic         r_err;
  logic [W-1:0] r_err_col;
  logic         r_pass;
  logic [W-1:0] r_bad_i;
  logic [W-1:0] r_bad_j;

  onehot_idx_t  w_enc;
  logic         w_word_ok;
  logic         w_accept;
  logic         w_last_col;
  logic         w_any_err;
  logic [W-1:0] w_i;
  logic [W-1:0] w_j;
  logic         w_last;
  logic         w_threat;

  assign w_enc      = onehot_to_idx(OH_MAX'(bus.in_data));
  assign w_word_ok  = w_enc.valid && (w_enc.idx < OH_IDX_W'(N));
  assign w_accept   = bus.in_valid && (r_state == CAPTURE) && !bus.start;
  assign w_last_col = (r_col == W'(N - 1));
  assign w_any_err  = r_err || !w_word_ok;

  pair_scanner #(.N(N), .W(W)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != CHECK),
    .i_adv    (r_state == CHECK),
    .i_row_a  (r_row[w_i]),
    .i_row_b  (r_row[w_j]),
    .o_i      (w_i),
    .o_j      (w_j),
    .o_last   (w_last),
    .o_threat (w_threat)
  );

  // Next-state decode; start restarts capture from any active state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = CAPTURE;
        else           w_next = IDLE;
      end
      CAPTURE: begin
        if (bus.start)                   w_next = CAPTURE;
        else if (w_accept && w_last_col) w_next = w_any_err ? DONE : CHECK;
        else                             w_next = CAPTURE;
      end
      CHECK: begin
        if (bus.start)              w_next = CAPTURE;
        else if (w_threat || w_last) w_next = DONE;
        else                        w_next = CHECK;
      end
      DONE: begin
        if (bus.start) w_next = CAPTURE;
        else           w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, row store, capture bookkeeping and the latched verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= {W{1'b0}};
      r_err     <= 1'b0;
      r_err_col <= {W{1'b0}};
      r_pass    <= 1'b0;
      r_bad_i   <= {W{1'b0}};
      r_bad_j   <= {W{1'b0}};
      for (int k = 0; k < N; k++) r_row[k] <= {W{1'b0}};
    end else if (bus.start) begin
      r_state   <= w_next;
      r_col     <= {W{1'b0}};
      r_err     <= 1'b0;
      r_err_col <= {W{1'b0}};
      r_pass    <= 1'b0;
      r_bad_i   <= {W{1'b0}};
      r_bad_j   <= {W{1'b0}};
      for (int k = 0; k < N; k++) r_row[k] <= {W{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_row[r_col] <= w_enc.idx[W-1:0];
        r_col        <= r_col + W'(1);
        if (!w_word_ok && !r_err) begin
          r_err     <= 1'b1;
          r_err_col <= r_col;
        end
        // A bad word in the final column is its own first offender.
        if (w_last_col && w_any_err) begin
          r_bad_i <= r_err ? r_err_col : r_col;
          r_bad_j <= r_err ? r_err_col : r_col;
          r_pass  <= 1'b0;
        end
      end else if (r_state == CHECK) begin
        if (w_threat) begin
          r_bad_i <= w_i;
          r_bad_j <= w_j;
          r_pass  <= 1'b0;
        end else if (w_last) begin
          r_pass  <= 1'b1;
        end else begin
          r_pass  <= r_pass;
        end
      end else begin
        r_pass <= r_pass;
      end
    end
  end

  assign bus.in_ready   = (r_state == CAPTURE);
  assign bus.busy       = (r_state == CAPTURE) || (r_state == CHECK);
  assign bus.done       = (r_state == DONE);
  assign bus.pass       = r_pass;
  assign bus.onehot_err = r_err;
  assign bus.bad_i      = r_bad_i;
  assign bus.bad_j      = r_bad_j;

endmodule
